multi_edge_filter: RTL
======================

// Module: multi_edge_filter
// PURPOSE
//   Parametrised N-channel glitch filter and edge detector for hall/commutation inputs.
//   Per channel: 2-flop synchroniser, DEPTH-sample window at a prescaled strobe rate,
//   LOW/HIGH hysteresis FSM. Outputs are the filtered level and one-clock edge pulses.
//   Sits between the raw sensor pins and the commutation logic. Runs on one clock
//   domain with a clock-enable strobe; no derived clocks.
// PARAMETERS
//   CH       3    number of independent input channels (>=1)
//   DEPTH    20   window length in samples (>=2)
//   PRESCALE 16   system clocks per sample strobe (>=1; 1 = sample every clock)
// PORTS
//   clock    in   1      system clock, all logic on rising edge
//   reset    in   1      asynchronous, active-low reset
//   enable   in   1      1 = prescaler and windows run; 0 = freeze all state
//   edge_mode in  2      00 rise, 01 fall, 10 both, 11 none; selects edge output
//   data     in   CH     raw asynchronous channel inputs
//   level    out  CH     filtered level per channel
//   rise     out  CH     1-clock pulse on a filtered 0->1 transition
//   fall     out  CH     1-clock pulse on a filtered 1->0 transition
//   edge     out  CH     rise/fall gated by edge_mode, 1-clock pulse
//   strobe   out  1      sample strobe (debug/verification visibility)
// BEHAVIOUR
//   Reset (reset=0, async): prescaler=0, sync flops=0, windows=0, all FSMs=LOW.
//     level/rise/fall/edge/strobe are all 0. Mid-operation reset aborts everything.
//   Prescaler: counts 0..PRESCALE-1 while enable=1, then wraps to 0.
//     strobe=1 in the cycle count==PRESCALE-1.
//     With PRESCALE=1, strobe=1 on every enabled cycle.
//   Synchroniser: free-running 2-flop stage per bit. Not gated by enable.
//   Window: on strobe, shift left and insert the synced bit at the LSB.
//     win_next = {win[DEPTH-2:0], s}. Updates only when strobe=1.
//   FSM per channel: evaluated on the same strobe edge, using win_next.
//     LOW  -> HIGH when win_next is all ones; otherwise stays LOW.
//     HIGH -> LOW  when win_next is all zeros; otherwise stays HIGH.
//     Mixed windows keep the current state (hysteresis).
//   level = (state==HIGH), registered.
//   rise/fall: asserted for exactly the one clock after the strobe edge that changes
//     state; deasserted on the next clock.
//   edge_mode behaviour:
//     edge = rise for 00, fall for 01, rise|fall for 10, 0 for 11.
//     edge is registered from the current edge_mode, so a mode change takes effect
//     on the next transition.
//   Latency: constant input change -> level change within 2 + DEPTH*PRESCALE
//     (+PRESCALE phase) clocks.
//   enable=0:
//     Prescaler, windows and FSMs hold. rise/fall/edge are forced to 0 next clock.
//     Re-enabling resumes from the held count; no spurious edge is generated.
//   Channels are fully independent. Simultaneous edges on several channels each
//     pulse in the same cycle.
// STRUCTURE
//   Package multi_edge_filter_pkg:
//     FSM state constants ST_LOW=1'b0, ST_HIGH=1'b1.
//     edge_mode encodings MODE_RISE, MODE_FALL, MODE_BOTH, MODE_NONE.
//     Function clog2 for the prescaler width, max(1, clog2(PRESCALE)).
//   Sub-module edge_filter_cell (one per channel, generate loop):
//     Contains the synchroniser, DEPTH window, FSM and rise/fall/edge regs.
//     Inputs: clock, reset, strobe, enable, edge_mode, din.
//   Top level holds the shared prescaler and the generate loop.
// TESTING (CH=3, DEPTH=4, PRESCALE=4 unless stated)
//   1. Reset: hold reset=0 with data=3'b111.
//      -> all outputs 0. After release with enable=0, level stays 000 indefinitely.
//   2. Clean step: enable=1, data[0] 0->1 and held.
//      -> level[0]=1 at the 4th strobe after the synced 1 arrives.
//      -> rise[0] and edge[0] (mode 00) pulse exactly 1 clock; fall stays 0.
//   3. Glitch reject: data[1] high for 3 strobes, then low.
//      -> level[1] stays 0; no pulses.
//      Then from HIGH, a 1-strobe low glitch -> level stays 1.
//   4. Modes:
//      mode=01, channel toggles 0->1->0 -> edge pulses only on the fall.
//      mode=10 -> two pulses. mode=11 -> none. rise/fall outputs unaffected.
//   5. Freeze: deassert enable after 2 of 4 high strobes, wait 50 clocks, re-enable.
//      -> level rises after 2 further strobes; strobe never asserts while enable=0.
//   6. Async reset mid-window and multi-channel:
//      data=3'b111 held, reset pulsed low between strobes -> outputs clear immediately.
//      After release all three channels rise together; rise=3'b111 for one clock.
//      Rerun with PRESCALE=1 to confirm strobe is continuously 1.

Source files
------------

// File: rtl/multi_edge_filter_pkg.sv
// Shared constants for the multi-channel glitch filter / edge detector.
// Hysteresis states, edge_mode encodings, prescaler width helpers.
package multi_edge_filter_pkg;

  typedef enum logic {
    ST_LOW  = 1'b0,
    ST_HIGH = 1'b1
  } state_e;

  localparam logic [1:0] MODE_RISE = 2'b00;
  localparam logic [1:0] MODE_FALL = 2'b01;
  localparam logic [1:0] MODE_BOTH = 2'b10;
  localparam logic [1:0] MODE_NONE = 2'b11;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // A one-clock prescaler still needs a 1-bit counter.
  function automatic int cnt_width(input int prescale);
    return (clog2(prescale) < 1) ? 1 : clog2(prescale);
  endfunction

endpackage

// File: rtl/multi_edge_filter_cell.sv
// One filter channel: 2-flop sync, DEPTH sample window, LOW/HIGH hysteresis FSM.
// Ports: clock, reset(n), strobe, enable, edge_mode, din -> level, rise, fall, edge_pulse.
module edge_filter_cell
  import multi_edge_filter_pkg::*;
#(
  parameter int DEPTH = 20
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       strobe,
  input  logic       enable,
  input  logic [1:0] edge_mode,
  input  logic       din,
  output logic       level,
  output logic       rise,
  output logic       fall,
  output logic       edge_pulse
);

  logic [1:0]       sync_q;
  logic [DEPTH-1:0] win_q;
  logic [DEPTH-1:0] win_next;
  state_e           state_q;
  state_e           state_next;
  logic             rise_next;
  logic             fall_next;
  logic             edge_next;

  // Synchroniser runs every clock, independent of enable.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], din};
    end
  end

  assign win_next = {win_q[DEPTH-2:0], sync_q[1]};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      win_q <= '0;
    end else if (strobe) begin
      win_q <= win_next;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_LOW;
    end else if (strobe) begin
      state_q <= state_next;
    end
  end

  // Mixed windows keep the current state: that is the hysteresis.
  always_comb begin
    state_next = state_q;
    unique case (state_q)
      ST_LOW:  if (&win_next)  state_next = ST_HIGH;
      ST_HIGH: if (~|win_next) state_next = ST_LOW;
    endcase
  end

  always_comb begin
    rise_next = strobe && (state_q == ST_LOW)
             && (state_next == ST_HIGH);
    fall_next = strobe && (state_q == ST_HIGH)
             && (state_next == ST_LOW);
    edge_next = 1'b0;
    case (edge_mode)
      MODE_RISE: edge_next = rise_next;
      MODE_FALL: edge_next = fall_next;
      MODE_BOTH: edge_next = rise_next | fall_next;
      default:   edge_next = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rise       <= 1'b0;
      fall       <= 1'b0;
      edge_pulse <= 1'b0;
    end else if (!enable) begin
      rise       <= 1'b0;
      fall       <= 1'b0;
      edge_pulse <= 1'b0;
    end else begin
      rise       <= rise_next;
      fall       <= fall_next;
      edge_pulse <= edge_next;
    end
  end

  assign level = (state_q == ST_HIGH);

endmodule

// File: rtl/multi_edge_filter.sv
// N-channel glitch filter and edge detector for hall/commutation inputs.
// Ports: clock, reset(n), enable, edge_mode, data[CH] -> level, rise, fall, edge_pulse, strobe.
module multi_edge_filter
  import multi_edge_filter_pkg::*;
#(
  parameter int CH       = 3,
  parameter int DEPTH    = 20,
  parameter int PRESCALE = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          enable,
  input  logic [1:0]    edge_mode,
  input  logic [CH-1:0] data,
  output logic [CH-1:0] level,
  output logic [CH-1:0] rise,
  output logic [CH-1:0] fall,
  output logic [CH-1:0] edge_pulse,
  output logic          strobe
);

  localparam int          PW   = cnt_width(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  // Reset term keeps strobe low while held in reset, even with PRESCALE=1.
  assign strobe = reset && enable && (cnt_q == LAST);

  for (genvar g = 0; g < CH; g++) begin : g_ch
    edge_filter_cell #(
      .DEPTH(DEPTH)
    ) u_cell (
      .clock     (clock),
      .reset     (reset),
      .strobe    (strobe),
      .enable    (enable),
      .edge_mode (edge_mode),
      .din       (data[g]),
      .level     (level[g]),
      .rise      (rise[g]),
      .fall      (fall[g]),
      .edge_pulse(edge_pulse[g])
    );
  end

endmodule
